comps_stim_seq: RTL

Upstream stimulus sequencer for the `comps` gate block. It drives `a`, `b1`, `b2`, `c1` and `c2` through a fixed pattern table, holding each pattern for a programmable number of cycles. At the end of each hold window it samples `comps` outputs `w`, `x` and `y`, and folds them into an 8-bit signature register for self-check. This replaces hand-timed stimulus with a clocked, restartable source usable both in simulation and on hardware.

---
 rtl/comps_pkg.sv | 35 +++
 rtl/comps_stim_seq_if.sv | 14 +
 rtl/comps_sig_lfsr.sv | 39 +++
 rtl/comps_stim_seq.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/comps_pkg.sv
// rtl/comps_pkg.sv - shared types, constants and pattern table for the comps stimulus sequencer
package comps_pkg;

  localparam int SIG_W = 8;

  // Feedback taps of the signature register: bits 7, 5, 4 and 3.
  localparam logic [SIG_W-1:0] SIG_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  typedef struct packed {
    logic a;
    logic b1;
    logic b2;
    logic c1;
    logic c2;
  } stim_t;

  // Pattern i drives a/b1/c1 from i[0] and b2/c2 from i[1].
  function automatic stim_t pattern(input logic [1:0] idx);
    stim_t s;
    s.a  = idx[0];
    s.b1 = idx[0];
    s.c1 = idx[0];
    s.b2 = idx[1];
    s.c2 = idx[1];
    return s;
  endfunction

endpackage

// File: rtl/comps_stim_seq_if.sv
// rtl/comps_stim_seq_if.sv - stimulus/response bus between the sequencer and the comps block
interface comps_stim_seq_if;
  logic a;
  logic b1;
  logic b2;
  logic c1;
  logic c2;
  logic w;
  logic x;
  logic y;

  modport master (output a, b1, b2, c1, c2, input w, x, y);
  modport slave  (input a, b1, b2, c1, c2, output w, x, y);
endinterface

// File: rtl/comps_sig_lfsr.sv
// rtl/comps_sig_lfsr.sv - 8-bit signature register with seed load and response folding
module comps_sig_lfsr
  import comps_pkg::*;
#(
  parameter logic [SIG_W-1:0] SEED = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [2:0]       din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;

  // Seed on load, otherwise shift with tap feedback and fold in the captured response.
  always_comb begin
    sig_d = sig_q;
    if (load) begin
      sig_d = SEED;
    end else if (en) begin
      sig_d = {sig_q[SIG_W-2:0], ^(sig_q & SIG_TAPS)} ^ {{(SIG_W-3){1'b0}}, din};
    end
  end

  // Signature state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/comps_stim_seq.sv
// rtl/comps_stim_seq.sv - clocked stimulus sequencer for comps; COMPS_SEQ_STABLE_CHK_EN adds the stability counter
module comps_stim_seq
  import comps_pkg::*;
#(
  parameter int               HOLD_CYCLES  = 10,
  parameter int               NUM_PATTERNS = 4,
  parameter logic [SIG_W-1:0] SIG_SEED     = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 loop_en,
  comps_stim_seq_if.master     cif,
  output logic                 busy,
  output logic                 done,
  output logic                 sample_valid,
  output logic [1:0]           pat_idx,
  output logic [2:0]           sample,
  output logic [SIG_W-1:0]     sig,
  output logic [7:0]           unstable_cnt
);

  localparam logic [7:0] HOLD_RELOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [1:0] LAST_IDX    = 2'(NUM_PATTERNS - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] pat_idx_q, pat_idx_d;
  logic [2:0] sample_q, sample_d;
  stim_t      stim_q, stim_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       sv_q, sv_d;
  logic       start_acc;
  logic       sig_en;
  logic [2:0] wxy;

  assign wxy = {cif.w, cif.x, cif.y};

  // Next-state and registered-output logic; stimulus follows the next state so it is valid
  // the cycle after start is accepted and drops to 0 as soon as DONE is entered.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pat_idx_d = pat_idx_q;
    sample_d  = sample_q;
    sv_d      = 1'b0;
    done_d    = 1'b0;
    start_acc = 1'b0;
    sig_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          pat_idx_d = 2'd0;
          cnt_d     = HOLD_RELOAD;
          state_d   = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_SAMPLE: begin
        sample_d = wxy;
        sv_d     = 1'b1;
        sig_en   = 1'b1;
        if (pat_idx_q < LAST_IDX) begin
          pat_idx_d = pat_idx_q + 2'd1;
          cnt_d     = HOLD_RELOAD;
          state_d   = ST_DRIVE;
        end else if (loop_en) begin
          pat_idx_d = 2'd0;
          cnt_d     = HOLD_RELOAD;
          state_d   = ST_DRIVE;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_DRIVE) || (state_d == ST_SAMPLE);
    stim_d = busy_d ? pattern(pat_idx_d) : '0;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pat_idx_q <= '0;
      sample_q  <= '0;
      stim_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pat_idx_q <= pat_idx_d;
      sample_q  <= sample_d;
      stim_q    <= stim_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sv_q      <= sv_d;
    end
  end

  comps_sig_lfsr #(
    .SEED (SIG_SEED)
  ) u_sig (
    .clk  (clk),
    .rst  (rst),
    .load (start_acc),
    .en   (sig_en),
    .din  (wxy),
    .sig  (sig)
  );

`ifdef COMPS_SEQ_STABLE_CHK_EN
  logic [2:0] prev_q, prev_d;
  logic       first_q, first_d;
  logic [7:0] ucnt_q, ucnt_d;

  // Count response changes inside a hold window; the first DRIVE cycle of each pattern is
  // skipped because the response is expected to move when the pattern changes.
  always_comb begin
    prev_d  = wxy;
    first_d = (state_d == ST_DRIVE) && (state_q != ST_DRIVE);
    ucnt_d  = ucnt_q;
    if (start_acc) begin
      ucnt_d = 8'd0;
    end else if ((state_q == ST_DRIVE) && !first_q && (wxy != prev_q) && (ucnt_q != 8'hFF)) begin
      ucnt_d = ucnt_q + 8'd1;
    end
  end

  // Stability tracking registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q  <= '0;
      first_q <= 1'b0;
      ucnt_q  <= '0;
    end else begin
      prev_q  <= prev_d;
      first_q <= first_d;
      ucnt_q  <= ucnt_d;
    end
  end

  assign unstable_cnt = ucnt_q;
`else
  assign unstable_cnt = 8'd0;
`endif

  assign cif.a        = stim_q.a;
  assign cif.b1       = stim_q.b1;
  assign cif.b2       = stim_q.b2;
  assign cif.c1       = stim_q.c1;
  assign cif.c2       = stim_q.c2;
  assign busy         = busy_q;
  assign done         = done_q;
  assign sample_valid = sv_q;
  assign pat_idx      = pat_idx_q;
  assign sample       = sample_q;

endmodule
